// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU operation codes, opcodes, operand selects
// and the decoded bundle passed from decode to execute.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_SGE  = 4'd4,
    ALU_SGEU = 4'd5,
    ALU_AND  = 4'd6,
    ALU_OR   = 4'd7,
    ALU_XOR  = 4'd8,
    ALU_SEQ  = 4'd9,
    ALU_SNE  = 4'd10,
    ALU_SL   = 4'd11,
    ALU_SR   = 4'd12,
    ALU_SRA  = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } op1_sel_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    alu_op_e         alu_op;
    op1_sel_e        op1_sel;
    logic            op2_sel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic            is_branch;
    logic            is_jump;
    logic            is_load;
    logic            is_store;
    logic            illegal;
  } dec_bundle_t;

  // Register/immediate arithmetic mapping shared by OP and OP-IMM.
  function automatic alu_op_e op_alu(input logic [2:0] funct3);
    alu_op_e op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SR;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if;
  import riscv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [3:0]      out_alu_op;
  logic [1:0]      out_op1_sel;
  logic            out_op2_sel;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_rd_we;
  logic            out_is_branch;
  logic            out_is_jump;
  logic            out_is_load;
  logic            out_is_store;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_alu_op, out_op1_sel, out_op2_sel,
           out_imm, out_rs1, out_rs2, out_rd, out_rd_we, out_is_branch,
           out_is_jump, out_is_load, out_is_store, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_alu_op, out_op1_sel, out_op2_sel,
           out_imm, out_rs1, out_rs2, out_rd, out_rd_we, out_is_branch,
           out_is_jump, out_is_load, out_is_store, out_illegal
  );

endinterface

// File: rtl/decode_stage_decoder.sv
// Purely combinational RV32I instruction-to-bundle mapping.
module rv32i_decoder
  import riscv_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_bundle_t bundle_o
);

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic            legal;
  dec_bundle_t     dec;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'h000};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // Opcode/funct decode; anything unrecognised collapses to a harmless ADD.
  always_comb begin
    dec     = '0;
    dec.rs1 = instr_i[19:15];
    dec.rs2 = instr_i[24:20];
    dec.rd  = instr_i[11:7];
    legal   = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec.rd_we = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec.alu_op = op_alu(funct3);
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.alu_op = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec.alu_op = ALU_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        dec.alu_op  = op_alu(funct3);
        dec.op2_sel = 1'b1;
        dec.imm     = imm_i;
        dec.rd_we   = 1'b1;
        case (funct3)
          3'b001: legal = (funct7 == 7'b0000000);
          3'b101: begin
            if (funct7 == 7'b0100000) begin
              dec.alu_op = ALU_SRA;
            end else begin
              legal = (funct7 == 7'b0000000);
            end
          end
          default: legal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.op2_sel = 1'b1;
        dec.imm     = imm_i;
        dec.rd_we   = 1'b1;
        dec.is_load = 1'b1;
      end
      OPC_STORE: begin
        dec.op2_sel  = 1'b1;
        dec.imm      = imm_s;
        dec.is_store = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm       = imm_b;
        dec.is_branch = 1'b1;
        case (funct3)
          3'b000:  dec.alu_op = ALU_SEQ;
          3'b001:  dec.alu_op = ALU_SNE;
          3'b100:  dec.alu_op = ALU_SLT;
          3'b101:  dec.alu_op = ALU_SGE;
          3'b110:  dec.alu_op = ALU_SLTU;
          3'b111:  dec.alu_op = ALU_SGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec.op1_sel = OP1_ZERO;
        dec.op2_sel = 1'b1;
        dec.imm     = imm_u;
        dec.rd_we   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op1_sel = OP1_PC;
        dec.op2_sel = 1'b1;
        dec.imm     = imm_u;
        dec.rd_we   = 1'b1;
      end
      OPC_JAL: begin
        dec.op1_sel = OP1_PC;
        dec.op2_sel = 1'b1;
        dec.imm     = imm_j;
        dec.rd_we   = 1'b1;
        dec.is_jump = 1'b1;
      end
      OPC_JALR: begin
        dec.op2_sel = 1'b1;
        dec.imm     = imm_i;
        dec.rd_we   = 1'b1;
        dec.is_jump = 1'b1;
        legal       = (funct3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec.alu_op    = ALU_ADD;
      dec.rd_we     = 1'b0;
      dec.is_branch = 1'b0;
      dec.is_jump   = 1'b0;
      dec.is_load   = 1'b0;
      dec.is_store  = 1'b0;
      dec.illegal   = 1'b1;
    end else begin
      dec.illegal   = 1'b0;
    end
    // Writes to x0 are architecturally discarded.
    dec.rd_we = dec.rd_we & (instr_i[11:7] != 5'd0);
  end

  assign bundle_o = dec;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode followed by a single output
// register with valid/ready handshakes on both sides and flush support.
module decode_stage
  import riscv_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  decode_stage_if.slave  bus
);

  stage_state_e    state_q, state_d;
  dec_bundle_t     bundle_q, bundle_d;
  logic [XLEN-1:0] pc_q, pc_d;
  dec_bundle_t     dec_bundle;
  logic            accept;

  rv32i_decoder u_decoder (
    .instr_i  (bus.in_instr),
    .bundle_o (dec_bundle)
  );

  assign bus.in_ready = !flush && ((state_q == ST_EMPTY) || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Output register state and payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      bundle_q <= '0;
      pc_q     <= '0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
      pc_q     <= pc_d;
    end
  end

  // Next state: flush wins, then a new beat, then draining to execute.
  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    pc_d     = pc_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d  = ST_FULL;
      bundle_d = dec_bundle;
      pc_d     = bus.in_pc;
    end else if (state_q == ST_FULL && bus.out_ready) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  assign bus.out_valid     = (state_q == ST_FULL);
  assign bus.out_pc        = pc_q;
  assign bus.out_alu_op    = bundle_q.alu_op;
  assign bus.out_op1_sel   = bundle_q.op1_sel;
  assign bus.out_op2_sel   = bundle_q.op2_sel;
  assign bus.out_imm       = bundle_q.imm;
  assign bus.out_rs1       = bundle_q.rs1;
  assign bus.out_rs2       = bundle_q.rs2;
  assign bus.out_rd        = bundle_q.rd;
  assign bus.out_rd_we     = bundle_q.rd_we;
  assign bus.out_is_branch = bundle_q.is_branch;
  assign bus.out_is_jump   = bundle_q.is_jump;
  assign bus.out_is_load   = bundle_q.is_load;
  assign bus.out_is_store  = bundle_q.is_store;
  assign bus.out_illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, handshake
// corner sequences and randomized traffic against a behavioural model.
module tb_decode_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  decode_stage_if ifc ();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (ifc)
  );

  typedef struct packed {
    logic [3:0]  alu;
    logic [1:0]  op1;
    logic        op2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic        jmp;
    logic        ld;
    logic        st;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic        m_valid = 1'b0;
  exp_t        m_b = '0;
  logic [31:0] m_pc = 32'h0;

  function automatic exp_t mk(input int alu, input int op1, input int op2, input logic [31:0] imm,
                              input int rs1, input int rs2, input int rd, input int we,
                              input int br, input int jmp, input int ld, input int st, input int ill);
    exp_t e;
    e.alu = 4'(alu);  e.op1 = 2'(op1); e.op2 = 1'(op2); e.imm = imm;
    e.rs1 = 5'(rs1);  e.rs2 = 5'(rs2); e.rd = 5'(rd);   e.we = 1'(we);
    e.br  = 1'(br);   e.jmp = 1'(jmp); e.ld = 1'(ld);   e.st = 1'(st); e.ill = 1'(ill);
    return e;
  endfunction

  // Reference decoder built from the instruction-set rules with table lookups.
  function automatic exp_t ref_decode(input logic [31:0] ins);
    int          opmap [8] = '{0, 11, 2, 3, 8, 12, 7, 6};
    int          brmap [8] = '{9, 10, -1, -1, 2, 4, 3, 5};
    int          f3  = int'(ins[14:12]);
    int          f7  = int'(ins[31:25]);
    int          opc = int'(ins[6:0]);
    logic [31:0] sx  = 32'($signed(ins) >>> 31);
    exp_t        e   = '0;
    bit          ok  = 1'b1;
    bit          we  = 1'b0;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    case (opc)
      'h33: begin
        we = 1'b1;
        if (f7 == 0) e.alu = 4'(opmap[f3]);
        else if (f7 == 32 && f3 == 0) e.alu = 4'd1;
        else if (f7 == 32 && f3 == 5) e.alu = 4'd13;
        else ok = 1'b0;
      end
      'h13: begin
        we = 1'b1; e.op2 = 1'b1; e.imm = 32'($signed(ins) >>> 20);
        e.alu = 4'(opmap[f3]);
        if (f3 == 1 && f7 != 0) ok = 1'b0;
        if (f3 == 5 && f7 == 32) e.alu = 4'd13;
        if (f3 == 5 && f7 != 32 && f7 != 0) ok = 1'b0;
      end
      'h03: begin we = 1'b1; e.op2 = 1'b1; e.ld = 1'b1; e.imm = 32'($signed(ins) >>> 20); end
      'h23: begin
        e.op2 = 1'b1; e.st = 1'b1;
        e.imm = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
      end
      'h63: begin
        if (brmap[f3] < 0) ok = 1'b0;
        else e.alu = 4'(brmap[f3]);
        e.br  = 1'b1;
        e.imm = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      end
      'h37: begin we = 1'b1; e.op1 = 2'd2; e.op2 = 1'b1; e.imm = ins & 32'hFFFFF000; end
      'h17: begin we = 1'b1; e.op1 = 2'd1; e.op2 = 1'b1; e.imm = ins & 32'hFFFFF000; end
      'h6F: begin
        we = 1'b1; e.op1 = 2'd1; e.op2 = 1'b1; e.jmp = 1'b1;
        e.imm = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      end
      'h67: begin
        we = 1'b1; e.op2 = 1'b1; e.jmp = 1'b1; e.imm = 32'($signed(ins) >>> 20);
        if (f3 != 0) ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    e.we = we && (ins[11:7] != 5'd0);
    if (!ok) begin
      e.alu = 4'd0; e.we = 1'b0; e.br = 1'b0; e.jmp = 1'b0; e.ld = 1'b0; e.st = 1'b0; e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_bundle(input string tag, input exp_t e, input logic [31:0] pc);
    chk({tag, ".illegal"}, 32'(ifc.out_illegal),   32'(e.ill));
    chk({tag, ".alu_op"},  32'(ifc.out_alu_op),    32'(e.alu));
    chk({tag, ".rd_we"},   32'(ifc.out_rd_we),     32'(e.we));
    chk({tag, ".branch"},  32'(ifc.out_is_branch), 32'(e.br));
    chk({tag, ".jump"},    32'(ifc.out_is_jump),   32'(e.jmp));
    chk({tag, ".load"},    32'(ifc.out_is_load),   32'(e.ld));
    chk({tag, ".store"},   32'(ifc.out_is_store),  32'(e.st));
    if (!e.ill) begin
      chk({tag, ".op1_sel"}, 32'(ifc.out_op1_sel), 32'(e.op1));
      chk({tag, ".op2_sel"}, 32'(ifc.out_op2_sel), 32'(e.op2));
      chk({tag, ".imm"},     ifc.out_imm,          e.imm);
      chk({tag, ".rs1"},     32'(ifc.out_rs1),     32'(e.rs1));
      chk({tag, ".rs2"},     32'(ifc.out_rs2),     32'(e.rs2));
      chk({tag, ".rd"},      32'(ifc.out_rd),      32'(e.rd));
      chk({tag, ".pc"},      ifc.out_pc,           pc);
    end
  endtask

  // One clock of traffic, entered and left on a falling edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    logic exp_rdy;
    ifc.in_valid = v; ifc.in_instr = ins; ifc.in_pc = pc; ifc.out_ready = rdy; flush = fl;
    #1;
    exp_rdy = !fl && (!m_valid || rdy);
    chk("in_ready", 32'(ifc.in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (fl) m_valid = 1'b0;
    else if (v && exp_rdy) begin
      m_valid = 1'b1; m_b = ref_decode(ins); m_pc = pc;
    end else if (rdy) m_valid = 1'b0;
    @(negedge clk);
    chk("out_valid", 32'(ifc.out_valid), 32'(m_valid));
    if (m_valid) chk_bundle("model", m_b, m_pc);
  endtask

  vec_t        tbl [11];
  logic [6:0]  opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h00};
  logic [31:0] r;
  logic [31:0] ins;
  logic [6:0]  f7;

  initial begin
    tbl[0]  = '{32'h002081B3, mk(0, 0, 0, 32'h0, 1, 2, 3, 1, 0, 0, 0, 0, 0)};
    tbl[1]  = '{32'h402081B3, mk(1, 0, 0, 32'h0, 1, 2, 3, 1, 0, 0, 0, 0, 0)};
    tbl[2]  = '{32'h40335293, mk(13, 0, 1, 32'h403, 6, 3, 5, 1, 0, 0, 0, 0, 0)};
    tbl[3]  = '{32'hFE209EE3, mk(10, 0, 0, 32'hFFFFFFFC, 1, 2, 29, 0, 1, 0, 0, 0, 0)};
    tbl[4]  = '{32'h123450B7, mk(0, 2, 1, 32'h12345000, 8, 3, 1, 1, 0, 0, 0, 0, 0)};
    tbl[5]  = '{32'h0000007F, mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[6]  = '{32'h00202063, mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[7]  = '{32'h008000EF, mk(0, 1, 1, 32'h8, 0, 8, 1, 1, 0, 1, 0, 0, 0)};
    tbl[8]  = '{32'h00000013, mk(0, 0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{32'h0020A223, mk(0, 0, 1, 32'h4, 1, 2, 4, 0, 0, 0, 0, 1, 0)};
    tbl[10] = '{32'hFF80A283, mk(0, 0, 1, 32'hFFFFFFF8, 1, 24, 5, 1, 0, 0, 1, 0, 0)};

    ifc.in_valid = 1'b0; ifc.in_instr = 32'h0; ifc.in_pc = 32'h0; ifc.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.out_valid", 32'(ifc.out_valid), 32'h0);
    chk_bundle("reset", '0, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("reset.in_ready", 32'(ifc.in_ready), 32'h1);
    @(negedge clk);

    // Directed vectors, issued back-to-back with execute always ready.
    for (int i = 0; i < 11; i++) begin
      step(1'b1, tbl[i].instr, 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
      chk_bundle($sformatf("vec%0d", i), tbl[i].e, 32'h1000 + 32'(4 * i));
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure: payload held and a new beat refused for three cycles.
    step(1'b1, 32'h002081B3, 32'h2000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h402081B3, 32'h2004, 1'b0, 1'b0);
      chk("stall.alu_op", 32'(ifc.out_alu_op), 32'd0);
      chk("stall.pc", ifc.out_pc, 32'h2000);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush while full with a beat offered: bundle dropped, beat refused.
    step(1'b1, 32'h123450B7, 32'h3000, 1'b0, 1'b0);
    step(1'b1, 32'h402081B3, 32'h3004, 1'b0, 1'b1);
    chk("flush.out_valid", 32'(ifc.out_valid), 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream.
    step(1'b1, 32'h40335293, 32'h4000, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(ifc.out_valid), 32'h0);
    chk("arst.alu_op", 32'(ifc.out_alu_op), 32'h0);
    chk("arst.imm", ifc.out_imm, 32'h0);
    m_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      r   = $urandom();
      ins = {r[31:7], opcs[$urandom_range(0, 9)]};
      case ($urandom_range(0, 2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = ins[31:25];
      endcase
      ins[31:25] = f7;
      step($urandom_range(0, 9) < 7, ins, $urandom(),
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined RV32I instruction decode stage sitting between fetch and the ALU/execute stage. It accepts one instruction per beat over a valid/ready handshake, decodes it into the 4-bit ALU operation code consumed by `alu`, plus operand selects, register indices and a sign-extended immediate. Results are registered once and presented to execute over a second valid/ready handshake. Flush support allows branch/jump redirects from execute.

## Interface
- `XLEN`, 32: datapath and immediate width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: discard the held instruction and the current input beat.
- `in_valid` in 1: fetch offers an instruction.
- `in_ready` out 1: decode accepts this cycle.
- `in_instr` in 32: raw instruction word.
- `in_pc` in XLEN: instruction address.
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: execute accepts the bundle.
- `out_pc` out XLEN: registered copy of `in_pc`.
- `out_alu_op` out 4: ALU operation code from the shared package.
- `out_op1_sel` out 2: 0 = rs1, 1 = PC, 2 = zero.
- `out_op2_sel` out 1: 0 = rs2, 1 = immediate.
- `out_imm` out XLEN: sign-extended immediate.
- `out_rs1`, `out_rs2`, `out_rd` out 5 each: register indices.
- `out_rd_we` out 1: writeback enable.
- `out_is_branch` out 1: conditional branch.
- `out_is_jump` out 1: JAL or JALR.
- `out_is_load` out 1: load instruction.
- `out_is_store` out 1: store instruction.
- `out_illegal` out 1: unsupported encoding.

## Operation
- **Output register states.** EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
  - `in_ready = !flush && (!out_valid || out_ready)`.
  - Accept when `in_valid && in_ready`: the register loads and the state goes FULL.
  - FULL with `out_ready` and no accept: the state goes EMPTY.
- **Flush.** Flush has priority over everything. The next state is EMPTY and the input beat in the flush cycle is not accepted.
- **OP (0110011).**
  - funct7 0000000: funct3 000 ADD, 001 SL, 010 SLT, 011 SLTU, 100 XOR, 101 SR, 110 OR, 111 AND.
  - funct7 0100000: only funct3 000 SUB and 101 SRA are legal.
  - `op2_sel=0`, `rd_we=1`.
- **OP-IMM (0010011).**
  - Uses the OP mapping with no SUB.
  - funct3 101 with imm[11:5]=0100000 gives SRA.
  - Shifts with any other non-zero imm[11:5] are illegal.
  - I-immediate, `op2_sel=1`.
- **LOAD (0000011) and STORE (0100011).** ADD with the I- or S-immediate respectively. Store has `rd_we=0`.
- **BRANCH (1100011).**
  - funct3 000 SEQ, 001 SNE, 100 SLT, 101 SGE, 110 SLTU, 111 SGEU; 010 and 011 are illegal.
  - `op2_sel=0`, B-immediate, `rd_we=0`.
- **LUI.** ADD, `op1_sel=zero`, U-immediate.
- **AUIPC.** ADD, `op1_sel=PC`, U-immediate.
- **JAL.** ADD, `op1_sel=PC`, J-immediate, `is_jump=1`.
- **JALR (funct3 000).** ADD, `op1_sel=rs1`, I-immediate, `is_jump=1`.
- **Illegal encodings.** Any other encoding sets `out_illegal=1` with `alu_op=ADD`, `rd_we=0` and all class flags 0.
- **rd = x0.** When rd is x0, `rd_we` is forced to 0.
- **Immediates.** Always sign-extended from instruction bit 31. U-type has its low 12 bits zero. B and J types have bit 0 zero.

## Timing
- Latency is one cycle from the accept edge to `out_valid`.
- Throughput is one instruction per cycle while `out_ready=1`.
- While `out_valid && !out_ready`, all `out_*` payload is held stable.
- Reset values: `out_valid=0` and all payload outputs 0 (so `alu_op` is ADD). `in_ready=1` after reset with `flush=0`.
- Reset asserted mid-stream drops the held bundle immediately (asynchronously).
- Simultaneous `out_ready` and accept: the old bundle leaves and the new bundle loads on the same edge, with no bubble.

## Structure
- **Shared package `riscv_pkg`** holds:
  - ALU codes: ADD=0, SUB=1, SLT=2, SLTU=3, SGE=4, SGEU=5, AND=6, OR=7, XOR=8, SEQ=9, SNE=10, SL=11, SR=12, SRA=13.
  - Opcode constants.
  - `op1_sel` encodings.
- **Sub-module `rv32i_decoder`:** purely combinational instruction-to-bundle mapping.
- **`decode_stage`:** instantiates `rv32i_decoder` and owns the output register and handshake.

## Test plan
- `add x3,x1,x2` (0x002081B3), then `sub` (0x402081B3) back-to-back with `out_ready=1`:
  - Two consecutive valid cycles.
  - `alu_op` 0 then 1, `rd=3`, `rs1=1`, `rs2=2`, `rd_we=1`.
- `srai x5,x6,3` (0x40335293): `alu_op=13`, `op2_sel=1`, `imm=0x403`, `rd=5`.
- `bne x1,x2,-4` (0xFE209EE3): `alu_op=10`, `is_branch=1`, `imm=0xFFFFFFFC`, `rd_we=0`.
- `lui x1,0x12345` (0x123450B7): `imm=0x12345000`, `op1_sel=2`, `alu_op=0`.
- Opcode 0x7F, and branch funct3 010: `illegal=1`, `rd_we=0`.
- Handshake stress:
  - Hold `out_ready=0` for 3 cycles: payload stable and `in_ready=0`.
  - Assert `flush` while FULL with `in_valid=1`: next cycle `out_valid=0` and the input beat is not accepted.
  - Pulse `rst_n` low mid-stream: `out_valid` drops immediately.
